// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Sweep sequencer for a 4-bit up/down counter. It accepts
//               single-sweep or ping-pong commands over valid/ready and is
//               the sole driver of the counter's load/mode/data pins.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_pingpong,
  input  logic [REP_W-1:0] cmd_legs,
  input  logic             abort,
  output logic             cnt_load,
  output logic             cnt_mode,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_count,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [REP_W-1:0] c_one = {{(REP_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt;        // endpoint of the current leg
  logic [WIDTH-1:0] r_alt;        // endpoint of the next leg (start value)
  logic             r_dir;        // 1 = counting up
  logic [REP_W-1:0] r_legs_left;  // legs still to run after the current one
  logic [WIDTH-1:0] r_hold;       // value the counter is parked on when idle
  logic             r_aborted;    // current command was ended by abort

  logic             w_match;
  logic [REP_W-1:0] w_legs_init;

  assign w_match = (cnt_count == r_tgt);

  // A leg count of 0 behaves like 1; single sweeps always run exactly one leg.
  assign w_legs_init = (cmd_pingpong && (cmd_legs != '0)) ? (cmd_legs - c_one) : '0;

  // Sequencer state and command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tgt       <= '0;
      r_alt       <= '0;
      r_dir       <= 1'b1;
      r_legs_left <= '0;
      r_hold      <= '0;
      r_aborted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_tgt       <= cmd_end;
            r_alt       <= cmd_start;
            r_dir       <= (cmd_end > cmd_start);
            r_legs_left <= w_legs_init;
            r_aborted   <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_hold    <= cnt_count;
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_hold    <= cnt_count;
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_match) begin
            if (r_legs_left != '0) begin
              // Turn around: the counter dwells on the endpoint this cycle.
              r_tgt       <= r_alt;
              r_alt       <= r_tgt;
              r_dir       <= ~r_dir;
              r_legs_left <= r_legs_left - c_one;
            end else begin
              r_hold  <= r_tgt;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_aborted <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Counter drive and status; RUN and abort outputs follow the live count.
  always_comb begin
    cmd_ready = 1'b0;
    cnt_load  = 1'b1;
    cnt_mode  = r_dir;
    cnt_data  = r_hold;
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_LOAD: begin
        busy     = 1'b1;
        cnt_data = abort ? cnt_count : r_alt;
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          cnt_load = 1'b1;
          cnt_data = cnt_count;
        end else begin
          cnt_load = w_match;
          cnt_data = r_tgt;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        aborted = r_aborted;
      end
      default: begin
        cnt_load = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Scoreboard bench for counter_seq_ctrl with a behavioural
//               4-bit up/down counter closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start = '0;
  logic [WIDTH-1:0] cmd_end = '0;
  logic             cmd_pingpong = 1'b0;
  logic [REP_W-1:0] cmd_legs = '0;
  logic             abort = 1'b0;
  logic             cnt_load;
  logic             cnt_mode;
  logic [WIDTH-1:0] cnt_data;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;
  logic             aborted;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic             ab;
    int               lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   chk_ready = 1'b0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_start    (cmd_start),
    .cmd_end      (cmd_end),
    .cmd_pingpong (cmd_pingpong),
    .cmd_legs     (cmd_legs),
    .abort        (abort),
    .cnt_load     (cnt_load),
    .cnt_mode     (cnt_mode),
    .cnt_data     (cnt_data),
    .cnt_count    (cnt),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  // Behavioural counter: load takes data, otherwise step by one each edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt <= '0;
    else if (cnt_load) cnt <= cnt_data;
    else if (cnt_mode) cnt <= cnt + 4'd1;
    else               cnt <= cnt - 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge counter and acceptance timestamp for latency measurement.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset && cmd_valid && cmd_ready) acc_cyc = cyc;
  end

  // Monitor: pops the scoreboard whenever the controller signals completion.
  always @(negedge clk) begin
    if (chk_ready) begin
      check("ready_after_done", cmd_ready, 1);
      check("busy_after_done", busy, 0);
      chk_ready = 1'b0;
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_count", cnt, e.val);
        check("done_hold_data", cnt_data, e.val);
        check("done_aborted", aborted, e.ab);
        check("done_latency", cyc - acc_cyc, e.lat);
        chk_ready = 1'b1;
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                       input logic pp, input logic [REP_W-1:0] legs,
                       input bit push, input logic [WIDTH-1:0] ev,
                       input logic eab, input int elat);
    @(negedge clk);
    if (push) q.push_back('{val: ev, ab: eab, lat: elat});
    cmd_valid    = 1'b1;
    cmd_start    = s;
    cmd_end      = e;
    cmd_pingpong = pp;
    cmd_legs     = legs;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cmd_start    = 4'($urandom);
    cmd_end      = 4'($urandom);
    cmd_pingpong = 1'($urandom);
    cmd_legs     = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=pending required=done (t=%0t)", $time);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_cnt_load"}, cnt_load, 1);
    check({tag, "_cnt_data"}, cnt_data, 0);
    check({tag, "_cnt_mode"}, cnt_mode, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 check_reset_vals("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single up sweep 3 -> 9: d=6, done after edge E8.
    issue(4'd3, 4'd9, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 8);
    @(negedge clk);
    check("load_cnt_load", cnt_load, 1);
    check("load_cnt_data", cnt_data, 3);
    check("load_busy", busy, 1);
    wait_idle();

    // Single down sweep 12 -> 5: d=7, latency 9.
    issue(4'd12, 4'd5, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 9);
    repeat (3) @(negedge clk);
    check("down_mode", cnt_mode, 0);
    check("down_count_e2", cnt, 11);
    wait_idle();
    repeat (3) @(negedge clk);
    check("down_idle_count", cnt, 5);
    check("down_idle_data", cnt_data, 5);

    // Ping-pong 2 <-> 5, three legs: final match after E12, done after E13.
    issue(4'd2, 4'd5, 1'b1, 4'd3, 1'b1, 4'd5, 1'b0, 13);
    repeat (7) @(negedge clk);
    check("pp_leg2_mode", cnt_mode, 0);
    check("pp_leg2_count", cnt, 4);
    repeat (4) @(negedge clk);
    check("pp_leg3_mode", cnt_mode, 1);
    check("pp_leg3_count", cnt, 3);
    wait_idle();

    // Equal endpoints, legs=0 ping-pong: one leg, done two cycles after accept.
    issue(4'd7, 4'd7, 1'b1, 4'd0, 1'b1, 4'd7, 1'b0, 2);
    wait_idle();

    // Abort at count 6 during 0 -> 15.
    issue(4'd0, 4'd15, 1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 8);
    repeat (8) @(negedge clk);
    check("abort_pre_count", cnt, 6);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("abort_idle_count", cnt, 6);
    check("abort_idle_data", cnt_data, 6);

    // Reset mid-sweep discards the command; a fresh 4 -> 1 then runs normally.
    issue(4'd0, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(4'd4, 4'd1, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 5);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
